// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM. After reset (or a
// clear request) it sweeps INIT_VALUE into every location, then serves the ports.
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDRESSES = 1024,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int AW = $clog2(ADDRESSES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [AW-1:0]         addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [AW-1:0]         addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  init_done,
  output logic                  ram_write,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  dbg_state_o
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    ram_write_q, ram_write_d;
  logic [AW-1:0]           ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_data_q, ram_data_d;
  logic                    tag_v_q, tag_v_d;
  logic                    tag_p_q, tag_p_d;
  logic                    rvalid0_q, rvalid1_q;
  logic                    gnt0_c, gnt1_c;

  // Handshake: a requester holds req_x (with we/addr/wdata stable) until it sees
  // gnt_x; the transfer happens at the rising edge where req_x and gnt_x are both
  // high. gnt_x is combinational, so a lone requester is served in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    tag_v_d     = 1'b0;
    tag_p_d     = tag_p_q;
    case (state_q)
      ST_INIT: begin
        ram_write_d = 1'b1;
        ram_addr_d  = cnt_q;
        ram_data_d  = INIT_VALUE;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == AW'(ADDRESSES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          // last_q==1 means port 1 was served last, so port 0 wins a contention.
          if (req0 && req1) begin
            gnt0_c = last_q;
            gnt1_c = ~last_q;
          end else begin
            gnt0_c = req0;
            gnt1_c = req1;
          end
          if (gnt0_c) begin
            ram_write_d = we0;
            ram_addr_d  = addr0;
            ram_data_d  = wdata0;
            last_d      = 1'b0;
            tag_v_d     = ~we0;
            tag_p_d     = 1'b0;
          end else if (gnt1_c) begin
            ram_write_d = we1;
            ram_addr_d  = addr1;
            ram_data_d  = wdata1;
            last_d      = 1'b1;
            tag_v_d     = ~we1;
            tag_p_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      tag_v_q     <= 1'b0;
      tag_p_q     <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      tag_v_q     <= tag_v_d;
      tag_p_q     <= tag_p_d;
      // Read tags keep flowing through a clear so issued reads still complete.
      rvalid0_q   <= tag_v_q & ~tag_p_q;
      rvalid1_q   <= tag_v_q & tag_p_q;
    end
  end

  // The RAM's registered output lines up with the second tag stage, so the
  // read data is steered straight through and zeroed when not valid.
  assign rdata0      = rvalid0_q ? ram_data_out : '0;
  assign rdata1      = rvalid1_q ? ram_data_out : '0;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign gnt0        = gnt0_c;
  assign gnt1        = gnt1_c;
  assign init_done   = (state_q == ST_RUN);
  assign ram_write   = ram_write_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural RAM plus a reference model of the
// arbitration rules; read responses are checked through an expected queue.
module tb_ram_arbiter;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int AW = $clog2(N);
  localparam logic [DW-1:0] INIT = 16'h5A5A;
  localparam int EW = 32 + 1 + DW;

  logic          clk, reset_n, clear;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, init_done, ram_write, dbg_state;
  logic [DW-1:0] rdata0, rdata1, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_addr;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDRESSES(N), .INIT_VALUE(INIT)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
    .init_done(init_done), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural single-port RAM ----------------
  logic [DW-1:0] ram_mem [N];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_data_in;
    ram_data_out <= ram_mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset_n && (rvalid0 || rvalid1)) begin
      if (rvalid0 && rvalid1) begin
        chk("rvalid_both", 64'({rvalid0, rvalid1}), 64'b01);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 64'({rvalid0, rvalid1}), 64'b00);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_port", 64'(rvalid1), 64'(e[DW]));
        chk("rdata", 64'(rvalid1 ? rdata1 : rdata0), 64'(e[DW-1:0]));
        chk("rvalid_latency", 64'(cyc), 64'(e[EW-1 -: 32]));
      end
    end
  end

  // ---------------- reference model ----------------
  bit            m_init;
  int            m_cnt;
  bit            m_last;
  logic [DW-1:0] ref_mem [N];
  logic          exp_rw;
  logic [AW-1:0] exp_ra;
  logic [DW-1:0] exp_rd;

  task automatic model_reset();
    m_init = 1'b1;
    m_cnt  = 0;
    m_last = 1'b1;
    exp_rw = 1'b0;
    exp_ra = '0;
    exp_rd = '0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; spans exactly one clock cycle.
  task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic clr, output int gp);
    int k;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    clear = clr;
    @(negedge clk);
    gp = -1;
    if (!m_init && !clr) begin
      if (r0 && r1) gp = m_last ? 0 : 1;
      else if (r0)  gp = 0;
      else if (r1)  gp = 1;
    end
    chk("gnt0", 64'(gnt0), 64'(gp == 0));
    chk("gnt1", 64'(gnt1), 64'(gp == 1));
    chk("init_done", 64'(init_done), 64'(!m_init));
    chk("dbg_state", 64'(dbg_state), 64'(!m_init));
    chk("ram_write", 64'(ram_write), 64'(exp_rw));
    chk("ram_addr", 64'(ram_addr), 64'(exp_ra));
    chk("ram_data_in", 64'(ram_data_in), 64'(exp_rd));
    k = cyc;
    @(posedge clk);
    if (m_init) begin
      exp_rw = 1'b1;
      exp_ra = AW'(m_cnt);
      exp_rd = INIT;
      ref_mem[m_cnt] = INIT;
      if (m_cnt == N - 1) m_init = 1'b0;
      m_cnt = m_cnt + 1;
    end else if (clr) begin
      exp_rw = 1'b0;
      m_init = 1'b1;
      m_cnt  = 0;
    end else if (gp >= 0) begin
      w = gp[0] ? w1 : w0;
      a = gp[0] ? a1 : a0;
      d = gp[0] ? d1 : d0;
      exp_rw = w;
      exp_ra = a;
      exp_rd = d;
      if (w) ref_mem[a] = d;
      else   exp_q.push_back({32'(k + 2), gp[0], ref_mem[a]});
      m_last = gp[0];
    end else begin
      exp_rw = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    int gp;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, gp);
  endtask

  // Called just after a rising edge: asserts reset immediately, holds it one edge.
  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    clear = 0;
    #1;
    chk("rst_gnt", 64'({gnt0, gnt1}), 64'b0);
    chk("rst_init_done", 64'(init_done), 64'b0);
    chk("rst_ram_write", 64'(ram_write), 64'b0);
    chk("rst_ram_addr", 64'(ram_addr), 64'b0);
    chk("rst_ram_data_in", 64'(ram_data_in), 64'b0);
    chk("rst_rvalid", 64'({rvalid0, rvalid1}), 64'b0);
    chk("rst_rdata", 64'({rdata0, rdata1}), 64'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gp;
    logic          p0, p1, pw0, pw1, clr;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    reset_n = 1'b0; clear = 0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Sweep with both ports held: no grants until init_done, then strict alternation from port 0.
    for (int i = 0; i < N + 4; i++) step(1, 0, 1, 0, 1, 0, 2, 0, 0, gp);
    idle(3);

    // Write then immediate read of the same address.
    step(1, 1, 5, 16'hBEEF, 0, 0, 0, 0, 0, gp);
    step(1, 0, 5, 0, 0, 0, 0, 0, 0, gp);
    idle(3);

    // Port 1 writes, port 0 reads back alongside a port 1 read.
    step(0, 0, 0, 0, 1, 1, 9, 16'h1234, 0, gp);
    step(1, 0, 9, 0, 1, 0, 5, 0, 0, gp);
    step(0, 0, 0, 0, 1, 0, 5, 0, 0, gp);
    idle(3);

    // Clear one cycle after a read accept: read still completes, full sweep follows.
    step(1, 0, 5, 0, 0, 0, 0, 0, 0, gp);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, gp);
    idle(N + 2);

    // Randomised traffic with held requests and occasional clears.
    p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; pw0 = 1'($urandom_range(0, 1)); pa0 = AW'($urandom_range(0, N - 1)); pd0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; pw1 = 1'($urandom_range(0, 1)); pa1 = AW'($urandom_range(0, N - 1)); pd1 = DW'($urandom);
      end
      clr = ($urandom_range(0, 79) == 0);
      step(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, clr, gp);
      if (gp == 0) p0 = 0;
      if (gp == 1) p1 = 0;
    end
    for (int i = 0; i < N + 1 && m_init; i++) idle(1);
    idle(3);

    // Reset one cycle after a read accept: the read is discarded, sweep restarts at 0.
    step(0, 0, 0, 0, 1, 0, 7, 0, 0, gp);
    do_reset();
    idle(N + 2);
    step(0, 0, 0, 0, 1, 0, 7, 0, 0, gp);
    idle(4);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
